// File: rtl/seq_calc_unit.sv
// seq_calc_unit: registered add/sub/mul/div unit with a start/busy/done handshake.
// Add, sub and divide-by-zero finish in one cycle. Multiply (shift-add, LSB first) and
// divide (restoring, MSB first) take one bit per cycle over WIDTH iteration cycles.
module seq_calc_unit #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         OP,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] S,
  output logic               busy,
  output logic               done,
  output logic               neg,
  output logic               zero,
  output logic               err
);

  localparam int unsigned RW = 2 * WIDTH;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpDiv = 2'b11;

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Multiply datapath: accumulator, left-shifting multiplicand, right-shifting multiplier.
  logic [RW-1:0]      acc_q, acc_d;
  logic [RW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  // Divide datapath: partial remainder, dividend shifting into quotient, divisor.
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  // Architectural outputs.
  logic [RW-1:0]      s_q, s_d;
  logic               neg_q, neg_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;

  logic [RW-1:0]      a_ext, b_ext;
  logic [RW-1:0]      add_res, sub_res;
  logic [RW-1:0]      mul_acc_nxt;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem_nxt, div_quo_nxt;

  logic [RW-1:0]      res;
  logic               res_neg, res_err, complete;

  // Single-cycle results straight from the operands presented at acceptance.
  always_comb begin
    a_ext   = {{WIDTH{1'b0}}, A};
    b_ext   = {{WIDTH{1'b0}}, B};
    add_res = a_ext + b_ext;
    // Full-width subtraction yields the sign-extended two's-complement difference.
    sub_res = a_ext - b_ext;
  end

  // One iteration step of the shift-add multiplier and the restoring divider.
  always_comb begin
    mul_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    div_shift   = {rem_q, quo_q[WIDTH-1]};
    div_ge      = (div_shift >= {1'b0, dvs_q});
    // When div_ge holds the difference is below the divisor, so WIDTH bits suffice.
    div_rem_nxt = div_ge ? (div_shift[WIDTH-1:0] - dvs_q) : div_shift[WIDTH-1:0];
    div_quo_nxt = {quo_q[WIDTH-2:0], div_ge};
  end

  // Next-state, datapath update and result capture.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    s_d      = s_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    err_d    = err_q;
    res      = s_q;
    res_neg  = 1'b0;
    res_err  = 1'b0;
    complete = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          op_d = OP;
          unique case (OP)
            OpAdd: begin
              res      = add_res;
              complete = 1'b1;
            end
            OpSub: begin
              res      = sub_res;
              res_neg  = (A < B);
              complete = 1'b1;
            end
            OpMul: begin
              acc_d    = '0;
              mcand_d  = a_ext;
              mplier_d = B;
              cnt_d    = CntLoad;
              state_d  = StIter;
            end
            OpDiv: begin
              if (B == '0) begin
                res      = {A, {WIDTH{1'b1}}};
                res_err  = 1'b1;
                complete = 1'b1;
              end else begin
                rem_d   = '0;
                quo_d   = A;
                dvs_d   = B;
                cnt_d   = CntLoad;
                state_d = StIter;
              end
            end
            default: ;
          endcase
        end
      end
      StIter: begin
        cnt_d = cnt_q - CntOne;
        if (op_q == OpMul) begin
          acc_d    = mul_acc_nxt;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          res      = mul_acc_nxt;
        end else begin
          rem_d = div_rem_nxt;
          quo_d = div_quo_nxt;
          res   = {div_rem_nxt, div_quo_nxt};
        end
        if (cnt_q == CntOne) begin
          complete = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (complete) begin
      state_d = StDone;
      s_d     = res;
      neg_d   = res_neg;
      err_d   = res_err;
      zero_d  = (res == '0);
    end
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      s_q      <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      s_q      <= s_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  // Outputs are all registered or decoded directly from the state register.
  always_comb begin
    S    = s_q;
    busy = (state_q == StIter);
    done = (state_q == StDone);
    neg  = neg_q;
    zero = zero_q;
    err  = err_q;
  end

endmodule

// File: tb/tb_seq_calc_unit.sv
// Randomized and directed checks of seq_calc_unit at WIDTH=4 and WIDTH=8 against an
// arithmetic reference model.
module tb_seq_calc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start8;
  logic [1:0]  op4, op8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [7:0]  s4;
  logic [15:0] s8;
  logic        busy4, done4, neg4, zero4, err4;
  logic        busy8, done8, neg8, zero8, err8;

  seq_calc_unit #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .OP    (op4),
    .A     (a4),
    .B     (b4),
    .S     (s4),
    .busy  (busy4),
    .done  (done4),
    .neg   (neg4),
    .zero  (zero4),
    .err   (err4)
  );

  seq_calc_unit #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .OP    (op8),
    .A     (a8),
    .B     (b8),
    .S     (s8),
    .busy  (busy8),
    .done  (done8),
    .neg   (neg8),
    .zero  (zero8),
    .err   (err8)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic        neg;
    logic        zero;
    logic [31:0] s;
  } res_t;

  int   n_total = 0;
  int   n_bad   = 0;
  res_t last4, last8;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's definition.
  function automatic res_t model(input int w, input logic [1:0] op,
                                 input int unsigned a, input int unsigned b);
    res_t        r;
    int unsigned mask;
    mask = (32'd1 << (2 * w)) - 32'd1;
    r    = '0;
    case (op)
      2'd0: r.s = a + b;
      2'd1: begin
        r.s   = (a - b) & mask;
        r.neg = (a < b);
      end
      2'd2: r.s = a * b;
      default: begin
        if (b == 0) begin
          r.s   = (a << w) | ((32'd1 << w) - 32'd1);
          r.err = 1'b1;
        end else begin
          r.s = ((a % b) << w) | (a / b);
        end
      end
    endcase
    r.zero = (r.s == 0);
    return r;
  endfunction

  task automatic drive(input int w, input bit st, input logic [1:0] op,
                       input int unsigned a, input int unsigned b);
    if (w == 8) begin
      start8 = st; op8 = op; a8 = 8'(a); b8 = 8'(b);
    end else begin
      start4 = st; op4 = op; a4 = 4'(a); b4 = 4'(b);
    end
  endtask

  function automatic res_t observe(input int w);
    res_t r;
    if (w == 8) begin
      r.s = {16'd0, s8}; r.neg = neg8; r.zero = zero8; r.err = err8;
    end else begin
      r.s = {24'd0, s4}; r.neg = neg4; r.zero = zero4; r.err = err4;
    end
    return r;
  endfunction

  function automatic logic obs_busy(input int w);
    return (w == 8) ? busy8 : busy4;
  endfunction

  function automatic logic obs_done(input int w);
    return (w == 8) ? done8 : done4;
  endfunction

  // Called at a negedge. Issues one operation, then walks its cycles checking busy/done,
  // that S holds its prior value until completion, and the final result. At cycle `poke`
  // a spurious start (A=1, B=1) is presented for one cycle; it must be ignored.
  task automatic run_op(input int w, input logic [1:0] op, input int unsigned a,
                        input int unsigned b, input int poke);
    res_t exp, last, got;
    bit   iter;
    int   lat;
    exp  = model(w, op, a, b);
    iter = (op == 2'd2) || (op == 2'd3 && b != 0);
    lat  = iter ? w + 1 : 1;
    last = (w == 8) ? last8 : last4;
    drive(w, 1'b1, op, a, b);
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == poke) begin
        drive(w, 1'b1, op, 1, 1);
      end else begin
        drive(w, 1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom);
      end
      check("busy", 32'(obs_busy(w)), 32'(iter && c <= w));
      check("done", 32'(obs_done(w)), 32'(c == lat));
      if (c < lat) begin
        got = observe(w);
        check("hold_s", got.s, last.s);
      end
    end
    got = observe(w);
    check("s", got.s, exp.s);
    check("neg", 32'(got.neg), 32'(exp.neg));
    check("zero", 32'(got.zero), 32'(exp.zero));
    check("err", 32'(got.err), 32'(exp.err));
    if (w == 8) last8 = exp;
    else        last4 = exp;
  endtask

  task automatic idle(input int w, input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_done", 32'(obs_done(w)), 32'd0);
      check("idle_busy", 32'(obs_busy(w)), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag, input int w);
    res_t got;
    got = observe(w);
    check({tag, "_s"}, got.s, 32'd0);
    check({tag, "_busy"}, 32'(obs_busy(w)), 32'd0);
    check({tag, "_done"}, 32'(obs_done(w)), 32'd0);
    check({tag, "_flags"}, {29'd0, got.err, got.neg, got.zero}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    int          w;
    logic [1:0]  op;
    int unsigned a, b;

    rst = 1'b1;
    drive(4, 1'b0, 2'd0, 0, 0);
    drive(8, 1'b0, 2'd0, 0, 0);
    last4 = '0;
    last8 = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst4", 4);
    check_reset_outputs("rst8", 8);
    rst = 1'b0;
    idle(4, 1);

    // Directed cases, WIDTH=4.
    run_op(4, 2'd0, 5, 3, 0);
    run_op(4, 2'd0, 15, 15, 0);
    run_op(4, 2'd1, 3, 10, 0);
    run_op(4, 2'd1, 15, 15, 0);
    idle(4, 1);
    run_op(4, 2'd2, 15, 15, 2);
    check("mul_e1", {24'd0, s4}, 32'h0000_00E1);
    run_op(4, 2'd3, 13, 4, 0);
    run_op(4, 2'd3, 9, 0, 0);
    check("div0_9f", {24'd0, s4}, 32'h0000_009F);

    // Reset in the middle of a multiply: outputs clear at once, no done pulse later.
    drive(4, 1'b1, 2'd2, 15, 15);
    @(posedge clk);
    @(negedge clk);
    drive(4, 1'b0, 2'd0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("async4", 4);
    last4 = '0;
    last8 = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op(4, 2'd2, 7, 6, 0);
    idle(4, 1);

    // Back-to-back: the next start is presented during the DONE cycle.
    run_op(4, 2'd2, 11, 13, 0);
    run_op(4, 2'd0, 9, 4, 0);
    run_op(4, 2'd3, 15, 2, 0);
    idle(4, 2);

    // WIDTH=8.
    run_op(8, 2'd2, 200, 200, 3);
    check("mul8_9c40", {16'd0, s8}, 32'h0000_9C40);
    run_op(8, 2'd3, 255, 7, 0);
    run_op(8, 2'd1, 0, 255, 0);
    idle(8, 1);

    // Randomized operations across both widths.
    for (int i = 0; i < 60; i++) begin
      w  = ($urandom_range(0, 1) == 1) ? 8 : 4;
      op = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, (1 << w) - 1);
      b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, (1 << w) - 1);
      run_op(w, op, a, b, (op == 2'd2 && $urandom_range(0, 1) == 1) ? 2 : 0);
      if ($urandom_range(0, 2) == 0) idle(w, 1);
    end
    idle(4, 1);
    idle(8, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_calc_unit.md
Name: seq_calc_unit

Overview:
Parametrised, registered successor to the 4-bit combinational adder/subtractor. It performs add, subtract, multiply and unsigned divide on WIDTH-bit operands under a start/busy/done handshake. Add and subtract complete in one cycle. Multiply (shift-add) and divide (restoring) iterate one bit per cycle. It sits between the calculator's operand/switch input logic and the display/BCD output stage.

Parameters:
WIDTH, 4, operand width in bits (legal 2..16); result width is 2*WIDTH
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
OP  input  2  operation: 00 add, 01 sub, 10 mul, 11 div
A  input  WIDTH  operand A (unsigned)
B  input  WIDTH  operand B (unsigned)
S  output  2*WIDTH  registered result
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse, S valid
neg  output  1  sub result negative (A<B)
zero  output  1  S == 0
err  output  1  divide by zero

Behaviour:
- Reset (async, any state): state=IDLE; S=0, busy=0, done=0, neg=0, zero=0, err=0; counter and internal registers cleared. An in-flight operation is abandoned, with no done pulse.
- States:
  - IDLE: wait for start.
  - ITER: mul/div iterations.
  - DONE: one cycle, done=1.
- Acceptance: start=1 with busy=0 at a rising edge (the "cycle 0" edge). A, B and OP are latched at that edge. Later input changes have no effect.
- ADD, SUB, or DIV with B=0: result computed from the latched operands. Next state is DONE, so S, flags and done=1 are visible in cycle 1. busy stays 0 for these.
- MUL and DIV with B!=0: state goes to ITER. busy=1 in cycles 1..WIDTH; counter runs WIDTH down to 1. S, done and flags are written on the edge leaving the last ITER cycle, so done=1 in cycle WIDTH+1.
- DONE always returns to IDLE the following edge; done is a single-cycle pulse.
- start with busy=1 is ignored (not queued). start during the DONE cycle is accepted normally (busy=0).
- S and flags hold their last values until the next completing operation. They are not cleared on start.
- Arithmetic:
  - ADD: S = zero-extended (WIDTH+1)-bit sum.
  - SUB: S = A-B as a 2*WIDTH-bit two's-complement value, sign-extended; neg = (A<B).
  - MUL: S = A*B, full 2*WIDTH bits; shift-add, one partial product per ITER cycle, LSB first.
  - DIV: restoring, one quotient bit per ITER cycle, MSB first; S = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
  - DIV with B=0: err=1; S = {A, all-ones quotient}; completes in cycle 1.
- Flags:
  - err is 0 for every other operation.
  - neg is 0 for non-SUB operations.
  - zero is computed from the final S of every operation.
- No X propagation: OP and operands are only sampled at acceptance.

Test Plan:
- WIDTH=4, reset then start OP=00, A=5, B=3 -> cycle 1: done=1, S=8'h08, neg=0, zero=0, busy=0. Also A=15, B=15 -> S=8'h1E.
- OP=01, A=3, B=10 -> cycle 1: S=8'hF9, neg=1. Also A=15, B=15 -> S=8'h00, zero=1, neg=0.
- OP=10, A=15, B=15 -> busy=1 in cycles 1-4, done=1 only in cycle 5, S=8'hE1. Start pulsed again in cycle 2 with A=1, B=1 -> ignored, S still 8'hE1.
- OP=11, A=13, B=4 -> done in cycle 5, S=8'h13 (r=1, q=3), err=0. Then A=9, B=0 -> done in cycle 1, S=8'h9F, err=1.
- Reset during OP=10 at cycle 2 -> all outputs 0 immediately (async), no done pulse follows. A new start in the cycle after reset release completes normally.
- Back-to-back: start held high across DONE -> the second operation is accepted in the DONE cycle. Repeat with WIDTH=8: A=200, B=200 mul -> done in cycle 9, S=16'h9C40.
